alu_request_driver: RTL and testbench

Sequential initiator for the team's combinational ALU submodules (comparison, arithmetic, logic units). It accepts an operation command over a valid/ready handshake, drives registered operands and an operation select into the submodule bank, and waits a fixed settle time. It then captures the selected submodule's result and 4-bit status and presents them downstream over a second valid/ready handshake. It also accumulates sticky status flags and counts completed transactions.

---
 rtl/alu_request_driver.sv | 165 ++++++++++++++++
 tb/tb_alu_request_driver.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_request_driver.sv
// -----------------------------------------------------------------------------
// alu_request_driver
//
// Sequential initiator for a bank of combinational ALU submodules. A command
// (operands + submodule select) is accepted over a valid/ready handshake and
// registered onto the submodule inputs. The operands are held for SETTLE
// cycles, then the selected submodule's result and status are captured and
// offered downstream over a second valid/ready handshake. Captured statuses
// are OR-accumulated into sticky flags, and completed output handshakes are
// counted.
//
// Parameters
//   M       operand width (two's complement, passed through untouched)
//   K       result width
//   SETTLE  cycles operands are held before capture, legal range 1..15
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready   command handshake
//   i_cmd_op, i_cmd_A, i_cmd_B  command payload
//   o_arg_A, o_arg_B, o_op      registered drive into the submodule bank
//   i_result, i_status          selected submodule response (status[3]=ovf)
//   o_valid / i_ready           result handshake
//   o_result, o_status          captured response
//   o_sticky, i_clr_sticky      accumulated status flags and their clear
//   o_count                     completed result handshakes, wraps at 2^16
// -----------------------------------------------------------------------------
module alu_request_driver #(
  parameter int M      = 8,
  parameter int K      = 8,
  parameter int SETTLE = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [1:0]   i_cmd_op,
  input  logic [M-1:0] i_cmd_A,
  input  logic [M-1:0] i_cmd_B,
  output logic [M-1:0] o_arg_A,
  output logic [M-1:0] o_arg_B,
  output logic [1:0]   o_op,
  input  logic [K-1:0] i_result,
  input  logic [3:0]   i_status,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [K-1:0] o_result,
  output logic [3:0]   o_status,
  output logic [3:0]   o_sticky,
  input  logic         i_clr_sticky,
  output logic [15:0]  o_count
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("alu_request_driver: SETTLE must be in 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // The counter is loaded with SETTLE-1 so that capture lands exactly
  // SETTLE edges after the accepting edge.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_e         state_q,  state_d;
  logic [3:0]     cnt_q,    cnt_d;
  logic [M-1:0]   arg_a_q,  arg_a_d;
  logic [M-1:0]   arg_b_q,  arg_b_d;
  logic [1:0]     op_q,     op_d;
  logic [K-1:0]   result_q, result_d;
  logic [3:0]     status_q, status_d;
  logic [3:0]     sticky_q, sticky_d;
  logic [15:0]    count_q,  count_d;
  logic           capture;

  // Next-state and datapath decode.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    arg_a_d  = arg_a_q;
    arg_b_d  = arg_b_q;
    op_d     = op_q;
    result_d = result_q;
    status_d = status_q;
    count_d  = count_q;
    capture  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          arg_a_d = i_cmd_A;
          arg_b_d = i_cmd_B;
          op_d    = i_cmd_op;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == 4'd0) begin
          capture  = 1'b1;
          result_d = i_result;
          status_d = i_status;
          state_d  = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        // i_ready is only looked at here, so an early i_ready is harmless.
        if (i_ready) begin
          count_d = count_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear in the capture cycle wipes the old flags but keeps the new
    // status; outside a capture the clear simply zeroes the flags.
    sticky_d = (i_clr_sticky ? 4'h0 : sticky_q) | (capture ? i_status : 4'h0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      arg_a_q  <= '0;
      arg_b_q  <= '0;
      op_q     <= 2'd0;
      result_q <= '0;
      status_q <= 4'h0;
      sticky_q <= 4'h0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      arg_a_q  <= arg_a_d;
      arg_b_q  <= arg_b_d;
      op_q     <= op_d;
      result_q <= result_d;
      status_q <= status_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  // Handshake outputs depend on state only, never on the incoming valid/ready.
  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_valid     = (state_q == ST_HOLD);
  assign o_arg_A     = arg_a_q;
  assign o_arg_B     = arg_b_q;
  assign o_op        = op_q;
  assign o_result    = result_q;
  assign o_status    = status_q;
  assign o_sticky    = sticky_q;
  assign o_count     = count_q;

endmodule

// File: tb/tb_alu_request_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_request_driver
//
// Self-checking bench for alu_request_driver. Two instances: u_dut with
// SETTLE=1 carries the directed table, backpressure, sticky, wrap, random and
// reset-in-HOLD scenarios; u_dut3 with SETTLE=3 covers the longer settle time.
// Expected values come from a transaction-level model (sticky flags and a
// handshake count) plus a small behavioural ALU used to generate responses.
// -----------------------------------------------------------------------------
module tb_alu_request_driver;

  logic        clk;
  logic        rst_n;
  logic        i_cmd_valid, i_cmd_valid3;
  logic [1:0]  i_cmd_op;
  logic [7:0]  i_cmd_a, i_cmd_b;
  logic [7:0]  i_result;
  logic [3:0]  i_status;
  logic        i_ready;
  logic        i_clr_sticky;

  logic        o_cmd_ready, o_valid;
  logic [7:0]  o_arg_a, o_arg_b, o_result;
  logic [1:0]  o_op;
  logic [3:0]  o_status, o_sticky;
  logic [15:0] o_count;

  logic        o_cmd_ready3, o_valid3;
  logic [7:0]  o_arg_a3, o_arg_b3, o_result3;
  logic [1:0]  o_op3;
  logic [3:0]  o_status3, o_sticky3;
  logic [15:0] o_count3;

  int          n_checks = 0;
  int          n_errors = 0;

  // Transaction-level reference state.
  logic [3:0]  m_sticky;
  logic [15:0] m_count;

  alu_request_driver #(.M(8), .K(8), .SETTLE(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_A(i_cmd_a), .i_cmd_B(i_cmd_b),
    .o_arg_A(o_arg_a), .o_arg_B(o_arg_b), .o_op(o_op),
    .i_result(i_result), .i_status(i_status),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_status(o_status),
    .o_sticky(o_sticky), .i_clr_sticky(i_clr_sticky),
    .o_count(o_count)
  );

  alu_request_driver #(.M(8), .K(8), .SETTLE(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid3), .o_cmd_ready(o_cmd_ready3),
    .i_cmd_op(i_cmd_op), .i_cmd_A(i_cmd_a), .i_cmd_B(i_cmd_b),
    .o_arg_A(o_arg_a3), .o_arg_B(o_arg_b3), .o_op(o_op3),
    .i_result(i_result), .i_status(i_status),
    .o_valid(o_valid3), .i_ready(i_ready),
    .o_result(o_result3), .o_status(o_status3),
    .o_sticky(o_sticky3), .i_clr_sticky(i_clr_sticky),
    .o_count(o_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural submodule bank: compare, add, and, xor.
  // Status: bit3 = signed overflow, bit0 = zero result.
  function automatic logic [11:0] alu_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic       ovf;
    ovf = 1'b0;
    case (op)
      2'd0: r = ($signed(a) > $signed(b)) ? 8'd1 : 8'd0;
      2'd1: begin
        r   = a + b;
        ovf = (a[7] == b[7]) && (r[7] != a[7]);
      end
      2'd2: r = a & b;
      default: r = a ^ b;
    endcase
    return {r, ovf, 2'b00, (r == 8'd0)};
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd_ready"}, 32'(o_cmd_ready), 32'd1);
    check({tag, "_valid"},     32'(o_valid),     32'd0);
    check({tag, "_arg_a"},     32'(o_arg_a),     32'd0);
    check({tag, "_arg_b"},     32'(o_arg_b),     32'd0);
    check({tag, "_op"},        32'(o_op),        32'd0);
    check({tag, "_result"},    32'(o_result),    32'd0);
    check({tag, "_status"},    32'(o_status),    32'd0);
    check({tag, "_sticky"},    32'(o_sticky),    32'd0);
    check({tag, "_count"},     32'(o_count),     32'd0);
  endtask

  // One full transaction on u_dut, entered and left at a falling edge in IDLE.
  // res/st are what the submodule presents during DRIVE; clr is raised for the
  // capture edge; hold = extra HOLD cycles with i_ready low and a competing
  // command; early = i_ready already high before o_valid rises.
  task automatic do_txn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] res, input logic [3:0] st, input logic clr,
                        input int hold, input logic early);
    int n;
    check("idle_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("idle_valid",     32'(o_valid),     32'd0);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_a     = a;
    i_cmd_b     = b;
    @(negedge clk);
    check("arg_a_after_accept", 32'(o_arg_a), 32'(a));
    check("arg_b_after_accept", 32'(o_arg_b), 32'(b));
    check("op_after_accept",    32'(o_op),    32'(op));
    check("drive_cmd_ready",    32'(o_cmd_ready), 32'd0);
    i_cmd_valid  = 1'b0;
    i_result     = res;
    i_status     = st;
    i_clr_sticky = clr;
    i_ready      = early;
    n = 0;
    while (o_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("settle_cycles", 32'(n), 32'd1);
    i_clr_sticky = 1'b0;
    m_sticky = (clr ? 4'h0 : m_sticky) | st;
    check("capture_result", 32'(o_result), 32'(res));
    check("capture_status", 32'(o_status), 32'(st));
    check("capture_sticky", 32'(o_sticky), 32'(m_sticky));
    check("count_before_hs", 32'(o_count), 32'(m_count));
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        i_cmd_valid = 1'b1;
        i_cmd_a     = ~a;
        i_cmd_b     = ~b;
        i_cmd_op    = ~op;
        i_result    = ~res;
        i_status    = ~st;
        @(negedge clk);
        check("bp_valid",     32'(o_valid),     32'd1);
        check("bp_cmd_ready", 32'(o_cmd_ready), 32'd0);
        check("bp_result",    32'(o_result),    32'(res));
        check("bp_status",    32'(o_status),    32'(st));
        check("bp_arg_a",     32'(o_arg_a),     32'(a));
        check("bp_arg_b",     32'(o_arg_b),     32'(b));
        check("bp_sticky",    32'(o_sticky),    32'(m_sticky));
      end
    end
    i_cmd_valid = 1'b0;
    i_ready     = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    m_count = m_count + 16'd1;
    check("hs_valid_drop",   32'(o_valid),     32'd0);
    check("hs_cmd_ready",    32'(o_cmd_ready), 32'd1);
    check("hs_count",        32'(o_count),     32'(m_count));
    check("idle_arg_a_kept", 32'(o_arg_a),     32'(a));
    check("idle_result_kept", 32'(o_result),   32'(res));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  res;
    logic [3:0]  st;
    logic        clr;
    int          hold;
    logic [3:0]  exp_sticky;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [11:0] rs;
    logic [1:0]  rop;
    logic [7:0]  ra, rb;

    vecs[0] = '{2'd0, 8'h05, 8'h03, 8'h01, 4'h0, 1'b0, 0, 4'h0, 16'd1};
    vecs[1] = '{2'd1, 8'h7F, 8'h01, 8'h80, 4'h8, 1'b0, 5, 4'h8, 16'd2};
    vecs[2] = '{2'd3, 8'h11, 8'h11, 8'h00, 4'h1, 1'b0, 0, 4'h9, 16'd3};
    vecs[3] = '{2'd2, 8'hF0, 8'h0F, 8'h00, 4'h2, 1'b1, 2, 4'h2, 16'd4};

    rst_n        = 1'b0;
    i_cmd_valid  = 1'b0;
    i_cmd_valid3 = 1'b0;
    i_cmd_op     = 2'd0;
    i_cmd_a      = 8'h00;
    i_cmd_b      = 8'h00;
    i_result     = 8'h00;
    i_status     = 4'h0;
    i_ready      = 1'b0;
    i_clr_sticky = 1'b0;
    m_sticky     = 4'h0;
    m_count      = 16'd0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state("reset");
    check("reset3_cmd_ready", 32'(o_cmd_ready3), 32'd1);
    check("reset3_valid",     32'(o_valid3),     32'd0);

    // Directed table: basic op, backpressure, sticky accumulate and clear.
    for (int i = 0; i < 4; i++) begin
      do_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].st,
             vecs[i].clr, vecs[i].hold, 1'b0);
      check("tbl_sticky", 32'(o_sticky), 32'(vecs[i].exp_sticky));
      check("tbl_count",  32'(o_count),  32'(vecs[i].exp_count));
    end

    // Counter wrap: preload the count to all-ones, then one more handshake.
    force u_dut.count_q = 16'hFFFF;
    @(negedge clk);
    release u_dut.count_q;
    @(negedge clk);
    m_count = 16'hFFFF;
    check("wrap_preload", 32'(o_count), 32'hFFFF);
    do_txn(2'd2, 8'h3C, 8'h0F, 8'h0C, 4'h0, 1'b0, 0, 1'b0);
    check("wrap_zero", 32'(o_count), 32'd0);

    // SETTLE=3: response changes every DRIVE cycle, last value must be taken.
    i_status     = 4'h4;
    i_cmd_valid3 = 1'b1;
    i_cmd_a      = 8'hA5;
    i_cmd_b      = 8'h5A;
    i_cmd_op     = 2'd1;
    @(negedge clk);
    i_cmd_valid3 = 1'b0;
    check("s3_arg_a", 32'(o_arg_a3), 32'hA5);
    check("s3_arg_b", 32'(o_arg_b3), 32'h5A);
    check("s3_op",    32'(o_op3),    32'd1);
    i_result = 8'hAA;
    @(negedge clk);
    check("s3_valid_c1", 32'(o_valid3), 32'd0);
    i_result = 8'hBB;
    @(negedge clk);
    check("s3_valid_c2", 32'(o_valid3), 32'd0);
    i_result = 8'hCC;
    @(negedge clk);
    check("s3_valid_c3",  32'(o_valid3),     32'd1);
    check("s3_result",    32'(o_result3),    32'hCC);
    check("s3_status",    32'(o_status3),    32'h4);
    check("s3_sticky",    32'(o_sticky3),    32'h4);
    check("s3_cmd_ready", 32'(o_cmd_ready3), 32'd0);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check("s3_valid_drop", 32'(o_valid3), 32'd0);
    check("s3_count",      32'(o_count3), 32'd1);

    // Randomised transactions against the reference model.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        i_clr_sticky = 1'b1;
        @(negedge clk);
        i_clr_sticky = 1'b0;
        m_sticky = 4'h0;
        check("rnd_idle_clear", 32'(o_sticky), 32'd0);
      end
      rop = 2'($urandom_range(0, 3));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rs  = alu_model(rop, ra, rb);
      do_txn(rop, ra, rb, rs[11:4], rs[3:0], ($urandom_range(0, 3) == 0),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        i_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        i_ready = 1'b0;
        check("rnd_idle_count", 32'(o_count), 32'(m_count));
      end
    end

    // Asynchronous reset pulse in the middle of HOLD.
    i_cmd_valid = 1'b1;
    i_cmd_a     = 8'h33;
    i_cmd_b     = 8'h44;
    i_cmd_op    = 2'd3;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_result    = 8'h5A;
    i_status    = 4'hF;
    @(negedge clk);
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_state("hold_rst");
    #1 rst_n = 1'b1;
    m_sticky = 4'h0;
    m_count  = 16'd0;
    @(negedge clk);
    check("post_rst_valid", 32'(o_valid), 32'd0);
    check("post_rst_count", 32'(o_count), 32'(m_count));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
